// File: rtl/seg_pkg.sv
// Shared definitions for the UART command framer: parser states, default
// sync marker and the frame checksum rule.
// No ports; imported by uart_cmd_framer.
package seg_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_CMD  = 3'd1,
    ST_DH   = 3'd2,
    ST_DL   = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

  // A frame is good when CMD+DH+DL+CHK sums to zero modulo 256.
  function automatic logic checksum_ok(input logic [7:0] acc, input logic [7:0] chk);
    logic [7:0] sum;
    sum = acc + chk;
    return (sum == 8'h00);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte idle timer: counts enabled cycles, restarts on clr, saturates.
// Ports: clk, rst_n (async active-low), clr (restart at 0, has priority),
//        en (count this cycle), expired (count has reached LIMIT-1).
module frame_timer #(
  parameter int LIMIT = 130200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      // Holding at LAST keeps expired asserted and stops any wrap.
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_framer.sv
// Parses SYNC,CMD,DH,DL,CHK frames from a UART receiver and publishes
// validated commands; result appears one clock after the CHK byte is consumed.
// Every offered byte is consumed the same cycle (clr_rdy = rdy), no stalling.
// Ports: clk, rst_n (async active-low); rdy/rx_data/clr_rdy (UART side);
//        cmd_rdy/cmd/data/clr_cmd_rdy (consumer side); chk_err/frm_err pulses.
module uart_cmd_framer
  import seg_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 130200,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        chk_err,
  output logic        frm_err
);

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  cmd_stg_q, cmd_stg_d;
  logic [7:0]  dh_stg_q, dh_stg_d;
  logic [7:0]  dl_stg_q, dl_stg_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        chk_err_q, chk_err_d;
  logic        frm_err_q, frm_err_d;
  logic        expired;

  // Gated by reset so the receiver never sees a consume strobe during reset.
  assign clr_rdy = rdy & rst_n;

  // Timer is held at zero in SYNC and restarted by every consumed byte,
  // which also covers entry to CMD.
  frame_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rdy || (state_q == ST_SYNC)),
    .en      (state_q != ST_SYNC),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cmd_stg_d = cmd_stg_q;
    dh_stg_d  = dh_stg_q;
    dl_stg_d  = dl_stg_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    // A good-frame set below overrides this clear.
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    chk_err_d = 1'b0;
    frm_err_d = 1'b0;

    if (rdy) begin
      // A byte in the timer's last cycle wins over the timeout.
      case (state_q)
        ST_SYNC: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_CMD;
            acc_d   = 8'h00;
          end
        end
        ST_CMD: begin
          cmd_stg_d = rx_data;
          acc_d     = acc_q + rx_data;
          state_d   = ST_DH;
        end
        ST_DH: begin
          dh_stg_d = rx_data;
          acc_d    = acc_q + rx_data;
          state_d  = ST_DL;
        end
        ST_DL: begin
          dl_stg_d = rx_data;
          acc_d    = acc_q + rx_data;
          state_d  = ST_CHK;
        end
        ST_CHK: begin
          if (checksum_ok(acc_q, rx_data)) begin
            cmd_d     = cmd_stg_q;
            data_d    = {dh_stg_q, dl_stg_q};
            cmd_rdy_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = ST_SYNC;
        end
        default: state_d = ST_SYNC;
      endcase
    end else if ((state_q != ST_SYNC) && expired) begin
      state_d   = ST_SYNC;
      frm_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SYNC;
      acc_q     <= 8'h00;
      cmd_stg_q <= 8'h00;
      dh_stg_q  <= 8'h00;
      dl_stg_q  <= 8'h00;
      cmd_q     <= 8'h00;
      data_q    <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      chk_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cmd_stg_q <= cmd_stg_d;
      dh_stg_q  <= dh_stg_d;
      dl_stg_q  <= dl_stg_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      chk_err_q <= chk_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign cmd_rdy = cmd_rdy_q;
  assign cmd     = cmd_q;
  assign data    = data_q;
  assign chk_err = chk_err_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Testbench for uart_cmd_framer: directed frames, expected outcomes queued
// by the stimulus thread and matched by an independent output monitor.
module tb_uart_cmd_framer;

  localparam int L = 40;

  localparam int K_GOOD = 0;
  localparam int K_CHK  = 1;
  localparam int K_FRM  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        chk_err;
  logic        frm_err;

  uart_cmd_framer #(.TIMEOUT_CYCLES(L), .SYNC_BYTE(8'hAA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .rx_data     (rx_data),
    .clr_rdy     (clr_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data),
    .chk_err     (chk_err),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [7:0]  cmd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   bytes_sent = 0;
  int   clr_seen = 0;
  int   last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_rdy = 1'b0;
  logic [7:0]  prev_cmd = 8'h00;
  logic [15:0] prev_data = 16'h0000;

  task automatic match_event(input int kind);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d cmd=%0h data=%0h at cyc %0d, none expected",
               kind, cmd, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == K_GOOD && (e.cmd != cmd || e.data != data))) begin
        errors++;
        $display("FAIL event: got kind=%0d cmd=%0h data=%0h cyc=%0d, expected kind=%0d cmd=%0h data=%0h cyc=%0d",
                 kind, cmd, data, cyc, e.kind, e.cmd, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy  = 1'b0;
      prev_cmd  = 8'h00;
      prev_data = 16'h0000;
    end else begin
      if (clr_rdy) clr_seen++;
      if (cmd_rdy && (!prev_rdy || cmd != prev_cmd || data != prev_data)) match_event(K_GOOD);
      if (chk_err) match_event(K_CHK);
      if (frm_err) match_event(K_FRM);
      prev_rdy  = cmd_rdy;
      prev_cmd  = cmd;
      prev_data = data;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called #1 after a clock edge; holds rdy for exactly one cycle.
  task automatic drive(input logic [7:0] b);
    rdy = 1'b1;
    rx_data = b;
    last_cyc = cyc;
    if (rst_n) bytes_sent++;
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    @(posedge clk); #1;
  endtask

  task automatic push(input int kind, input logic [7:0] c, input logic [15:0] d, input int at);
    exp_t e;
    e.kind = kind; e.cmd = c; e.data = d; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4,
                       input int kind, input logic [7:0] c, input logic [15:0] d);
    send(b0); send(b1); send(b2); send(b3);
    drive(b4);
    push(kind, c, d, last_cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic ack(input string name);
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    chk(name, {31'b0, cmd_rdy}, 32'd0);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int n;
  initial begin
    // Reset, with a byte offered to prove no consume strobe leaks out.
    rst_n = 1'b0;
    rdy = 1'b1;
    rx_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clr_rdy", {31'b0, clr_rdy}, 32'd0);
    chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    chk("rst_cmd", {24'b0, cmd}, 32'h00);
    chk("rst_data", {16'b0, data}, 32'h0000);
    chk("rst_chk_err", {31'b0, chk_err}, 32'd0);
    chk("rst_frm_err", {31'b0, frm_err}, 32'd0);
    rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bad checksum: chk_err only, outputs keep reset values.
    frame(8'hAA, 8'h01, 8'h12, 8'h34, 8'hB8, K_CHK, 8'h00, 16'h0000);
    chk("bad_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    chk("bad_cmd", {24'b0, cmd}, 32'h00);
    chk("bad_data", {16'b0, data}, 32'h0000);

    // Good frame.
    frame(8'hAA, 8'h01, 8'h12, 8'h34, 8'hB9, K_GOOD, 8'h01, 16'h1234);
    ack("ack1");

    // Leading junk is discarded.
    send(8'h55); send(8'h3C);
    frame(8'hAA, 8'h05, 8'h00, 8'h00, 8'hFB, K_GOOD, 8'h05, 16'h0000);
    ack("ack2");

    // Sync value inside the frame is plain data: AA*3 = 1FE -> FE, CHK 02.
    frame(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h02, K_GOOD, 8'hAA, 16'hAAAA);
    ack("ack3");

    // Byte lands exactly in the timer's final cycle: byte wins, no timeout.
    send(8'hAA);
    drive(8'h01);
    n = last_cyc;
    idle_until(n + L);
    send(8'h12);
    send(8'h34);
    drive(8'hB9);
    push(K_GOOD, 8'h01, 16'h1234, last_cyc + 1);
    @(posedge clk); #1;
    ack("ack4");

    // Timeout after AA 01, then recovery.
    send(8'hAA);
    drive(8'h01);
    push(K_FRM, 8'h00, 16'h0000, last_cyc + 1 + L);
    n = last_cyc;
    idle_until(n + L + 4);
    chk("tmo_cmd_rdy", {31'b0, cmd_rdy}, 32'd0);
    frame(8'hAA, 8'h02, 8'h00, 8'h01, 8'hFD, K_GOOD, 8'h02, 16'h0001);
    ack("ack5");

    // Overwrite while cmd_rdy is still set.
    frame(8'hAA, 8'h03, 8'h00, 8'h00, 8'hFD, K_GOOD, 8'h03, 16'h0000);
    frame(8'hAA, 8'h04, 8'h00, 8'h01, 8'hFB, K_GOOD, 8'h04, 16'h0001);
    chk("ovr_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    chk("ovr_cmd", {24'b0, cmd}, 32'h04);
    ack("ack6");

    // Acknowledge coincident with frame completion: set wins.
    send(8'hAA); send(8'h07); send(8'h00); send(8'h00);
    clr_cmd_rdy = 1'b1;
    drive(8'hF9);
    clr_cmd_rdy = 1'b0;
    push(K_GOOD, 8'h07, 16'h0000, last_cyc + 1);
    chk("race_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    ack("race_ack");

    // Reset mid-frame discards the partial frame.
    send(8'hAA); send(8'h01); send(8'h12);
    rst_n = 1'b0;
    rdy = 1'b1;
    rx_data = 8'h34;
    #2;
    chk("mid_rst_clr_rdy", {31'b0, clr_rdy}, 32'd0);
    chk("mid_rst_cmd", {24'b0, cmd}, 32'h00);
    @(posedge clk); #1;
    rdy = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame(8'hAA, 8'h01, 8'h12, 8'h34, 8'hB9, K_GOOD, 8'h01, 16'h1234);
    chk("post_rst_data", {16'b0, data}, 32'h1234);

    repeat (5) @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 32'd0);
    chk("clr_rdy_per_byte", clr_seen, bytes_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 130200, idle clocks allowed between bytes inside a frame (5 byte times at 19200 baud, 50 MHz).
REQ-002 Parameter: SYNC_BYTE, 8'hAA, frame start marker.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  byte-available flag from the UART receiver.
REQ-006 rx_data  input  8  received byte, valid while rdy=1.
REQ-007 clr_rdy  output  1  consume strobe to the UART receiver.
REQ-008 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 cmd_rdy  output  1  a validated frame is held on cmd/data.
REQ-010 cmd  output  8  command byte of the last good frame.
REQ-011 data  output  16  payload of the last good frame, {DH,DL}.
REQ-012 chk_err  output  1  one-cycle pulse on a checksum failure.
REQ-013 frm_err  output  1  one-cycle pulse on an inter-byte timeout.

Function
REQ-014 Frame format SHALL be SYNC_BYTE, CMD, DH, DL, CHK, received in that order.
REQ-015 A byte SHALL be consumed in any cycle with rdy=1, and clr_rdy SHALL be asserted combinationally for exactly that cycle.
REQ-016 Since rdy falls on the following edge, each byte SHALL be consumed exactly once.
REQ-017 The FSM SHALL have states SYNC, CMD, DH, DL, CHK, and SHALL advance one state per consumed byte.
REQ-018 In SYNC, a byte other than SYNC_BYTE SHALL be consumed and discarded, and the FSM SHALL remain in SYNC.
REQ-019 In SYNC, SYNC_BYTE SHALL move the FSM to CMD and clear the checksum accumulator.
REQ-020 In CMD, DH and DL, the consumed byte SHALL be latched into a staging register and added into an 8-bit accumulator modulo 256.
REQ-021 In CHK, the frame SHALL be good iff (accumulator + CHK) mod 256 == 8'h00.
REQ-022 The FSM SHALL return to SYNC after CHK in all cases.
REQ-023 On a good frame, cmd/data SHALL update from the staging registers and cmd_rdy SHALL be set, both on the clock edge after the CHK byte is consumed (1-cycle latency).
REQ-024 On a bad frame, cmd/data/cmd_rdy SHALL be unchanged, and chk_err SHALL pulse high for one cycle at that same edge.
REQ-025 cmd_rdy SHALL clear on clr_cmd_rdy.
REQ-026 If clr_cmd_rdy and good-frame set occur in the same cycle, set SHALL win.
REQ-027 A new good frame while cmd_rdy=1 SHALL overwrite cmd/data, and cmd_rdy SHALL stay 1.
REQ-028 An inter-byte timer SHALL count only in CMD, DH, DL and CHK, and SHALL restart at 0 on every consumed byte and on entry to CMD.
REQ-029 When the timer reaches TIMEOUT_CYCLES-1 with no byte consumed that cycle, the FSM SHALL return to SYNC and frm_err SHALL pulse for one cycle.
REQ-030 When a byte arrives in the same cycle as the timer limit, the byte SHALL win and no timeout SHALL occur.
REQ-031 The timer SHALL saturate and never wrap, and its width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-032 A SYNC_BYTE value inside CMD, DH, DL or CHK SHALL be treated as data, with no resynchronisation.

Reset
REQ-033 On rst_n low: state=SYNC, cmd_rdy=0, cmd=8'h00, data=16'h0000, chk_err=0, frm_err=0, timer=0, accumulator=0.
REQ-034 clr_rdy SHALL be 0 while rst_n is low.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame.
REQ-036 After reset deassertion, parsing SHALL begin in SYNC with no spurious strobes.

Structure
REQ-037 The state enum and SYNC_BYTE default SHALL live in shared package seg_pkg.
REQ-038 The inter-byte timer SHALL be sub-module frame_timer (inputs clr, en; output expired).
REQ-039 All other logic SHALL be flat inside uart_cmd_framer.

Verification
REQ-040 Bytes AA 01 12 34 B9 -> cmd_rdy=1, cmd=8'h01, data=16'h1234, one cycle after CHK is consumed; chk_err=0.
REQ-041 Bytes AA 01 12 34 B8 -> chk_err pulses once; cmd_rdy stays 0; cmd/data keep their reset values.
REQ-042 Bytes 55 3C AA 05 00 00 FB -> the first two bytes are discarded; cmd_rdy=1, cmd=8'h05, data=16'h0000.
REQ-043 Bytes AA 01 then no byte for TIMEOUT_CYCLES clocks -> frm_err pulses once and state=SYNC; a following frame AA 02 00 01 FD is accepted with cmd=8'h02, data=16'h0001.
REQ-044 clr_cmd_rdy asserted in the same cycle a good frame (AA 07 00 00 F9) completes -> cmd_rdy=1; clr_cmd_rdy asserted one cycle later -> cmd_rdy=0.
REQ-045 rst_n pulsed low after AA 01 12, then frame AA 01 12 34 B9 sent -> exactly one cmd_rdy with data=16'h1234; clr_rdy seen exactly once per byte.
